// File: rtl/clint_pkg.sv
// Shared definitions for the core-local interruptor: register offsets, bus FSM states
// and the byte-lane merge used by every writable register.
package clint_pkg;

  localparam int unsigned CLINT_MSIP        = 32'h00;
  localparam int unsigned CLINT_MTIMECMP_LO = 32'h08;
  localparam int unsigned CLINT_MTIMECMP_HI = 32'h0C;
  localparam int unsigned CLINT_MTIME_LO    = 32'h10;
  localparam int unsigned CLINT_MTIME_HI    = 32'h14;

  typedef enum logic {IDLE, RESP} clint_state_t;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_mtime_counter.sv
// Prescaled 64-bit machine timer. A bus write to either half wins over a coincident tick.
module clint_mtime_counter
  import clint_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  byte_en_i,
  output logic [63:0] mtime_o,
  output logic [63:0] mtime_next_o
);

  logic [31:0] presc_q, presc_d;
  logic [63:0] mtime_q, mtime_d;
  logic        tick;

  always_comb begin
    tick    = (presc_q == 32'(PRESCALE - 1));
    presc_d = tick ? 32'd0 : presc_q + 32'd1;

    mtime_d = mtime_q;
    if (wr_lo_i) mtime_d[31:0]  = byte_merge(mtime_q[31:0], wdata_i, byte_en_i);
    if (wr_hi_i) mtime_d[63:32] = byte_merge(mtime_q[63:32], wdata_i, byte_en_i);
    // Tick is dropped when software rewrites mtime; prescaler keeps its phase.
    if (!(wr_lo_i || wr_hi_i) && tick) mtime_d = mtime_q + 64'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q <= '0;
      mtime_q <= '0;
    end else begin
      presc_q <= presc_d;
      mtime_q <= mtime_d;
    end
  end

  assign mtime_o      = mtime_q;
  assign mtime_next_o = mtime_d;

endmodule

// File: rtl/priv_1_11_clint.sv
// Core-local interruptor: bus slave for msip/mtimecmp/mtime, raising machine timer and
// software interrupts plus clear pulses for the privilege logic.
module priv_1_11_clint
  import clint_pkg::*;
#(
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned ADDR_W   = 5
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ren,
  input  logic              wen,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [3:0]        byte_en,
  output logic [31:0]       rdata,
  output logic              busy,
  output logic [63:0]       mtime_out,
  output logic              timer_int_m,
  output logic              soft_int_m,
  output logic              clear_timer_int_m,
  output logic              clear_soft_int_m
);

  clint_state_t state_q, state_d;
  logic [63:0]  mtimecmp_q, mtimecmp_d;
  logic         msip_q, msip_d;
  logic         timer_q, timer_d;
  logic         clr_timer_q, clr_timer_d;
  logic         clr_soft_q, clr_soft_d;
  logic [63:0]  mtime_next;
  logic         ack, wr;
  logic         sel_msip, sel_cmp_lo, sel_cmp_hi, sel_mt_lo, sel_mt_hi;

  assign ack        = (state_q == RESP);
  assign wr         = ack && wen;
  assign sel_msip   = (addr == ADDR_W'(CLINT_MSIP));
  assign sel_cmp_lo = (addr == ADDR_W'(CLINT_MTIMECMP_LO));
  assign sel_cmp_hi = (addr == ADDR_W'(CLINT_MTIMECMP_HI));
  assign sel_mt_lo  = (addr == ADDR_W'(CLINT_MTIME_LO));
  assign sel_mt_hi  = (addr == ADDR_W'(CLINT_MTIME_HI));

  clint_mtime_counter #(
    .PRESCALE(PRESCALE)
  ) u_mtime (
    .clk_i       (CLK),
    .rst_ni      (nRST),
    .wr_lo_i     (wr && sel_mt_lo),
    .wr_hi_i     (wr && sel_mt_hi),
    .wdata_i     (wdata),
    .byte_en_i   (byte_en),
    .mtime_o     (mtime_out),
    .mtime_next_o(mtime_next)
  );

  always_comb begin
    state_d    = (state_q == IDLE && (ren || wen)) ? RESP : IDLE;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    if (wr && sel_cmp_lo) mtimecmp_d[31:0]  = byte_merge(mtimecmp_q[31:0], wdata, byte_en);
    if (wr && sel_cmp_hi) mtimecmp_d[63:32] = byte_merge(mtimecmp_q[63:32], wdata, byte_en);
    if (wr && sel_msip && byte_en[0]) msip_d = wdata[0];
    // Compare next-state values so the interrupt tracks the edge that changes either side.
    timer_d     = (mtime_next >= mtimecmp_d);
    clr_timer_d = timer_q && !timer_d;
    clr_soft_d  = msip_q && !msip_d;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      mtimecmp_q  <= '1;
      msip_q      <= 1'b0;
      timer_q     <= 1'b0;
      clr_timer_q <= 1'b0;
      clr_soft_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mtimecmp_q  <= mtimecmp_d;
      msip_q      <= msip_d;
      timer_q     <= timer_d;
      clr_timer_q <= clr_timer_d;
      clr_soft_q  <= clr_soft_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (ack) begin
      if (sel_msip)   rdata = {31'd0, msip_q};
      if (sel_cmp_lo) rdata = mtimecmp_q[31:0];
      if (sel_cmp_hi) rdata = mtimecmp_q[63:32];
      if (sel_mt_lo)  rdata = mtime_out[31:0];
      if (sel_mt_hi)  rdata = mtime_out[63:32];
    end
  end

  assign busy              = !ack;
  assign timer_int_m       = timer_q;
  assign soft_int_m        = msip_q;
  assign clear_timer_int_m = clr_timer_q;
  assign clear_soft_int_m  = clr_soft_q;

endmodule

// File: tb/tb_priv_1_11_clint.sv
// Bench for priv_1_11_clint: two instances (PRESCALE 1 and 4) share one bus and are
// checked every cycle against an arithmetic model, plus table vectors and corner sequences.
module tb_priv_1_11_clint;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        ren = 1'b0, wen = 1'b0;
  logic [4:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  byte_en = '0;

  logic [31:0] rd  [2];
  logic        bsy [2];
  logic [63:0] mt  [2];
  logic        ti  [2];
  logic        si  [2];
  logic        ct  [2];
  logic        cs  [2];

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  priv_1_11_clint #(.PRESCALE(1), .ADDR_W(5)) u_p1 (
    .CLK(CLK), .nRST(nRST), .ren(ren), .wen(wen), .addr(addr), .wdata(wdata),
    .byte_en(byte_en), .rdata(rd[0]), .busy(bsy[0]), .mtime_out(mt[0]),
    .timer_int_m(ti[0]), .soft_int_m(si[0]), .clear_timer_int_m(ct[0]),
    .clear_soft_int_m(cs[0])
  );

  priv_1_11_clint #(.PRESCALE(4), .ADDR_W(5)) u_p4 (
    .CLK(CLK), .nRST(nRST), .ren(ren), .wen(wen), .addr(addr), .wdata(wdata),
    .byte_en(byte_en), .rdata(rd[1]), .busy(bsy[1]), .mtime_out(mt[1]),
    .timer_int_m(ti[1]), .soft_int_m(si[1]), .clear_timer_int_m(ct[1]),
    .clear_soft_int_m(cs[1])
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [63:0]     m_mtime [2];
  logic [63:0]     m_cmp   [2];
  logic            m_msip  [2];
  logic            m_timer [2];
  logic            m_ct    [2];
  logic            m_cs    [2];
  logic            m_resp;
  longint unsigned m_n;

  function automatic longint unsigned pval(input int i);
    return (i == 0) ? 64'd1 : 64'd4;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mread(input int i, input logic [4:0] a);
    case (a)
      5'h00:   return {31'd0, m_msip[i]};
      5'h08:   return m_cmp[i][31:0];
      5'h0C:   return m_cmp[i][63:32];
      5'h10:   return m_mtime[i][31:0];
      5'h14:   return m_mtime[i][63:32];
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < 2; i++) begin
        m_mtime[i] = '0; m_cmp[i] = '1; m_msip[i] = 1'b0;
        m_timer[i] = 1'b0; m_ct[i] = 1'b0; m_cs[i] = 1'b0;
      end
      m_resp = 1'b0;
      m_n    = 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        logic [63:0] nt, nc;
        logic        ns, wr, tick, ntim;
        wr   = m_resp && wen;
        tick = (m_n % pval(i)) == pval(i) - 1;
        nt = m_mtime[i]; nc = m_cmp[i]; ns = m_msip[i];
        if (wr && addr == 5'h00 && byte_en[0]) ns = wdata[0];
        if (wr && addr == 5'h08) nc[31:0]  = merge(nc[31:0], wdata, byte_en);
        if (wr && addr == 5'h0C) nc[63:32] = merge(nc[63:32], wdata, byte_en);
        if (wr && addr == 5'h10)      nt[31:0]  = merge(nt[31:0], wdata, byte_en);
        else if (wr && addr == 5'h14) nt[63:32] = merge(nt[63:32], wdata, byte_en);
        else if (tick)                nt = nt + 64'd1;
        ntim       = (nt >= nc);
        m_ct[i]    = m_timer[i] && !ntim;
        m_cs[i]    = m_msip[i] && !ns;
        m_timer[i] = ntim;
        m_mtime[i] = nt; m_cmp[i] = nc; m_msip[i] = ns;
      end
      m_n    = m_n + 1;
      m_resp = !m_resp && (ren || wen);
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge CLK) begin
    if (nRST) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("p%0d_mtime", i), mt[i], m_mtime[i]);
        chk($sformatf("p%0d_busy", i), 64'(bsy[i]), 64'(!m_resp));
        chk($sformatf("p%0d_timer", i), 64'(ti[i]), 64'(m_timer[i]));
        chk($sformatf("p%0d_soft", i), 64'(si[i]), 64'(m_msip[i]));
        chk($sformatf("p%0d_clr_timer", i), 64'(ct[i]), 64'(m_ct[i]));
        chk($sformatf("p%0d_clr_soft", i), 64'(cs[i]), 64'(m_cs[i]));
        if (m_resp) chk($sformatf("p%0d_rdata", i), 64'(rd[i]), 64'(mread(i, addr)));
      end
    end
  end

  // Called at posedge+2; returns at posedge+2 of the edge that leaves the acknowledge cycle.
  task automatic bus(input logic r, input logic w, input logic [4:0] a, input logic [31:0] d,
                     input logic [3:0] be, output logic [31:0] rdv);
    bit got = 0;
    ren = r; wen = w; addr = a; wdata = d; byte_en = be;
    rdv = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      if (!bsy[0]) begin got = 1; rdv = rd[0]; break; end
    end
    if (!got) chk("bus_ack_timeout", 64'd0, 64'd1);
    @(posedge CLK); #2;
    ren = 1'b0; wen = 1'b0;
  endtask

  typedef struct {
    logic        r, w;
    logic [4:0]  a;
    logic [31:0] d;
    logic [3:0]  be;
    bit          cmp;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];
  logic [31:0] rdv;
  bit rose;

  initial begin
    vecs.push_back('{1'b0, 1'b1, 5'h08, 32'hAAAA5555, 4'hF, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 5'h08, 32'h0,        4'h0, 1'b1, 32'hAAAA5555});
    vecs.push_back('{1'b1, 1'b1, 5'h08, 32'h12345678, 4'hF, 1'b1, 32'hAAAA5555});
    vecs.push_back('{1'b1, 1'b0, 5'h08, 32'h0,        4'h0, 1'b1, 32'h12345678});
    vecs.push_back('{1'b0, 1'b1, 5'h0C, 32'h00000007, 4'h1, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 5'h0C, 32'h0,        4'h0, 1'b1, 32'h00000007});
    vecs.push_back('{1'b0, 1'b1, 5'h0C, 32'hFFFFFFFF, 4'h6, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 5'h0C, 32'h0,        4'h0, 1'b1, 32'h00FFFF07});
    vecs.push_back('{1'b0, 1'b1, 5'h00, 32'h00000003, 4'h1, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 5'h00, 32'h0,        4'h0, 1'b1, 32'h00000001});
    vecs.push_back('{1'b0, 1'b1, 5'h18, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 5'h18, 32'h0,        4'h0, 1'b1, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 5'h04, 32'h0,        4'h0, 1'b1, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 5'h1C, 32'h0,        4'h0, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 1'b1, 5'h00, 32'h0,        4'hF, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 1'b0, 5'h00, 32'h0,        4'h0, 1'b1, 32'h0});

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("reset_busy", 64'(bsy[0]), 64'd1);
    chk("reset_rdata", 64'(rd[0]), 64'd0);
    nRST = 1'b1;

    // Idle after reset.
    repeat (10) @(posedge CLK);
    #2;
    chk("idle_mtime_p1", mt[0], 64'd10);
    chk("idle_mtime_p4", mt[1], 64'd2);
    chk("idle_timer", 64'(ti[0]), 64'd0);

    // Timer rises when mtime reaches 20.
    bus(1'b0, 1'b1, 5'h08, 32'd20, 4'hF, rdv);
    bus(1'b0, 1'b1, 5'h0C, 32'd0, 4'hF, rdv);
    rose = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge CLK);
      if (ti[0]) begin rose = 1; break; end
    end
    chk("timer_rise_seen", 64'(rose), 64'd1);
    chk("timer_rise_mtime", mt[0], 64'd20);
    @(posedge CLK); #2;

    // Raising mtimecmp hi deasserts the timer with a single clear pulse.
    bus(1'b0, 1'b1, 5'h0C, 32'd1, 4'hF, rdv);
    @(negedge CLK);
    chk("timer_fall", 64'(ti[0]), 64'd0);
    chk("clr_timer_pulse", 64'(ct[0]), 64'd1);
    @(negedge CLK);
    chk("clr_timer_one_cycle", 64'(ct[0]), 64'd0);
    @(posedge CLK); #2;

    // Carry from lo into hi, then full 64-bit wrap.
    bus(1'b0, 1'b1, 5'h10, 32'hFFFFFFFF, 4'hF, rdv);
    @(negedge CLK);
    chk("mtime_written", mt[0], 64'h0000_0000_FFFF_FFFF);
    @(negedge CLK);
    chk("mtime_carry", mt[0], 64'h0000_0001_0000_0000);
    @(posedge CLK); #2;
    bus(1'b0, 1'b1, 5'h14, 32'hFFFFFFFF, 4'hF, rdv);
    bus(1'b0, 1'b1, 5'h10, 32'hFFFFFFFF, 4'hF, rdv);
    @(negedge CLK);
    chk("mtime_all_ones", mt[0], 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge CLK);
    chk("mtime_wrap", mt[0], 64'd0);
    @(posedge CLK); #2;

    // msip set/clear and byte-enable masking.
    bus(1'b0, 1'b1, 5'h00, 32'd1, 4'hF, rdv);
    @(negedge CLK);
    chk("msip_set", 64'(si[0]), 64'd1);
    @(posedge CLK); #2;
    bus(1'b0, 1'b1, 5'h00, 32'd0, 4'hF, rdv);
    @(negedge CLK);
    chk("msip_clear", 64'(si[0]), 64'd0);
    chk("clr_soft_pulse", 64'(cs[0]), 64'd1);
    @(negedge CLK);
    chk("clr_soft_one_cycle", 64'(cs[0]), 64'd0);
    @(posedge CLK); #2;
    bus(1'b0, 1'b1, 5'h00, 32'd1, 4'hE, rdv);
    @(negedge CLK);
    chk("msip_be_masked", 64'(si[0]), 64'd0);
    @(posedge CLK); #2;

    // Write to mtime on the same edge as a PRESCALE=4 tick: no increment.
    while (((m_n + 1) % 4) != 3) begin
      @(posedge CLK); #2;
    end
    bus(1'b0, 1'b1, 5'h10, 32'h00000100, 4'hF, rdv);
    @(negedge CLK);
    chk("tick_lost_p4", 64'(mt[1][31:0]), 64'h100);
    chk("tick_lost_p1", 64'(mt[0][31:0]), 64'h100);
    @(posedge CLK); #2;

    // Table-driven register vectors.
    foreach (vecs[v]) begin
      bus(vecs[v].r, vecs[v].w, vecs[v].a, vecs[v].d, vecs[v].be, rdv);
      if (vecs[v].cmp) chk($sformatf("vec%0d_rdata", v), 64'(rdv), 64'(vecs[v].exp));
    end

    // Random traffic against the model.
    for (int t = 0; t < 300; t++) begin
      logic [1:0] rw;
      rw = 2'($urandom_range(1, 3));
      bus(rw[0], rw[1], 5'($urandom_range(0, 7) * 4), $urandom, 4'($urandom), rdv);
      repeat ($urandom_range(0, 2)) begin
        @(posedge CLK); #2;
      end
    end

    // Reset during the acknowledge cycle discards the pending write.
    ren = 1'b0; wen = 1'b1; addr = 5'h08; wdata = 32'd0; byte_en = 4'hF;
    rose = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      if (!bsy[0]) begin rose = 1; break; end
    end
    chk("rst_resp_reached", 64'(rose), 64'd1);
    #1 nRST = 1'b0;
    #1;
    chk("rst_mtime_p1", mt[0], 64'd0);
    chk("rst_mtime_p4", mt[1], 64'd0);
    chk("rst_busy", 64'(bsy[0]), 64'd1);
    chk("rst_timer", 64'(ti[0]), 64'd0);
    chk("rst_soft", 64'(si[0]), 64'd0);
    wen = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK); #2;
    bus(1'b1, 1'b0, 5'h08, 32'd0, 4'h0, rdv);
    chk("rst_cmp_lo", 64'(rdv), 64'hFFFFFFFF);
    bus(1'b1, 1'b0, 5'h0C, 32'd0, 4'h0, rdv);
    chk("rst_cmp_hi", 64'(rdv), 64'hFFFFFFFF);
    repeat (2) @(posedge CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
